// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
package dmem_pkg;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_LATENCY     = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between a requester (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array with per-byte write mask; the read data
// register only updates on an enabled load, so it holds across the response.
import dmem_pkg::*;

module dmem_array #(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request at a time, waits
// LATENCY cycles, then presents the response until the requester takes it.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | latency countdown in progress
//   RESP  | response presented, waiting for rsp_ready
import dmem_pkg::*;

module dmem_responder #(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]      LIMIT    = 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             err_q, err_d;

  logic          idle, accept, req_err, fire;
  logic          a_we, a_err;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic [31:0]   arr_rdata;

  assign idle    = (state_q == ST_IDLE);
  assign accept  = idle && bus.req_valid;
  assign req_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, bus.req_addr} >= LIMIT);

  // With LATENCY=1 the array is accessed on the acceptance edge itself, so
  // it must see the live request rather than the captured copy.
  assign a_we    = idle ? bus.req_we              : we_q;
  assign a_idx   = idle ? bus.req_addr[AW+1:2]    : idx_q;
  assign a_wdata = idle ? bus.req_wdata           : wdata_q;
  assign a_be    = idle ? bus.req_be              : be_q;
  assign a_err   = idle ? req_err                 : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[AW+1:2];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          err_d   = req_err;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .en_i    (fire && !a_err && !reset),
    .we_i    (a_we),
    .be_i    (a_be),
    .idx_i   (a_idx),
    .wdata_i (a_wdata),
    .rdata_o (arr_rdata)
  );

  assign bus.req_ready = idle;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.rsp_rdata = (bus.rsp_valid && !we_q && !err_q) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: same scenario list run on a LATENCY=2 and a LATENCY=1 instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  int   lat;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        t_valid, t_we, t_rsp_ready;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;

  always #5 clk = ~clk;

  dmem_responder_if bus_l2 ();
  dmem_responder_if bus_l1 ();

  assign bus_l2.req_valid = t_valid & ~sel;
  assign bus_l2.req_we    = t_we;
  assign bus_l2.req_addr  = t_addr;
  assign bus_l2.req_wdata = t_wdata;
  assign bus_l2.req_be    = t_be;
  assign bus_l2.rsp_ready = t_rsp_ready & ~sel;
  assign bus_l1.req_valid = t_valid & sel;
  assign bus_l1.req_we    = t_we;
  assign bus_l1.req_addr  = t_addr;
  assign bus_l1.req_wdata = t_wdata;
  assign bus_l1.req_be    = t_be;
  assign bus_l1.rsp_ready = t_rsp_ready & sel;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (.clk(clk), .reset(rst), .bus(bus_l2));
  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (.clk(clk), .reset(rst), .bus(bus_l1));

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  assign o_req_ready = sel ? bus_l1.req_ready : bus_l2.req_ready;
  assign o_rsp_valid = sel ? bus_l1.rsp_valid : bus_l2.rsp_valid;
  assign o_rsp_err   = sel ? bus_l1.rsp_err   : bus_l2.rsp_err;
  assign o_rsp_rdata = sel ? bus_l1.rsp_rdata : bus_l2.rsp_rdata;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (lat=%0d) observed=%h expected=%h", tag, lat, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; with hold>0 the response is stalled and a copy of
  // the same request is kept pending so the next call re-issues it.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                     input int hold, input string tag);
    int n;
    t_valid = 1'b1; t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
    chk(32'(o_req_ready), 32'd1, {tag, ".req_ready"});
    tick();
    t_valid = 1'b0; t_we = ~we; t_addr = 32'hFFFF_FFFD; t_wdata = ~wdata; t_be = ~be;
    n = 1;
    while (!o_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk(32'(n), 32'(lat), {tag, ".latency"});
    chk(32'(o_rsp_err), 32'(exp_err), {tag, ".rsp_err"});
    chk(o_rsp_rdata, exp_rd, {tag, ".rsp_rdata"});
    chk(32'(o_req_ready), 32'd0, {tag, ".busy_ready"});
    if (hold > 0) begin
      t_valid = 1'b1; t_we = we; t_addr = addr; t_wdata = wdata; t_be = be;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk(32'(o_rsp_valid), 32'd1, {tag, ".hold_valid"});
        chk(o_rsp_rdata, exp_rd, {tag, ".hold_rdata"});
        chk(32'(o_req_ready), 32'd0, {tag, ".hold_ready"});
      end
    end
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
    chk(32'(o_rsp_valid), 32'd0, {tag, ".done_valid"});
    chk(32'(o_req_ready), 32'd1, {tag, ".done_ready"});
  endtask

  task automatic run_suite();
    txn(1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 0, "st_full");
    txn(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 0, "ld_full");
    txn(1'b1, 32'h10,  32'h000000AA, 4'b0001, 32'h0,        1'b0, 0, "st_byte0");
    txn(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 0, "ld_merge");
    txn(1'b1, 32'h0,   32'h01234567, 4'b1111, 32'h0,        1'b0, 0, "st_w0");
    txn(1'b0, 32'h13,  32'h0,        4'b0000, 32'h0,        1'b1, 0, "ld_misalign");
    txn(1'b1, 32'h400, 32'h11111111, 4'b1111, 32'h0,        1'b1, 0, "st_range");
    txn(1'b1, 32'h12,  32'h22222222, 4'b1111, 32'h0,        1'b1, 0, "st_misalign");
    txn(1'b0, 32'h0,   32'h0,        4'b0000, 32'h01234567, 1'b0, 0, "ld_w0_kept");
    txn(1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 0, "st_be0");
    txn(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 0, "ld_after_be0");
    txn(1'b1, 32'h3FC, 32'hA5A5C3C3, 4'b1111, 32'h0,        1'b0, 0, "st_top");
    txn(1'b0, 32'h3FC, 32'h0,        4'b0000, 32'hA5A5C3C3, 1'b0, 0, "ld_top");
    txn(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 5, "ld_stall");
    txn(1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 0, "ld_after_stall");
    txn(1'b1, 32'h20,  32'hCAFEF00D, 4'b1111, 32'h0,        1'b0, 0, "st_w20");
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; lat = 2;
    t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_be = '0; t_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk(32'(bus_l2.req_ready), 32'd1, "rst_l2.req_ready");
    chk(32'(bus_l2.rsp_valid), 32'd0, "rst_l2.rsp_valid");
    chk(bus_l2.rsp_rdata,      32'h0, "rst_l2.rsp_rdata");
    chk(32'(bus_l2.rsp_err),   32'd0, "rst_l2.rsp_err");
    chk(32'(bus_l1.req_ready), 32'd1, "rst_l1.req_ready");
    chk(32'(bus_l1.rsp_valid), 32'd0, "rst_l1.rsp_valid");

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = (s == 0) ? 2 : 1;
      run_suite();
    end

    // Reset while a store is in WAIT on the LATENCY=2 instance.
    sel = 1'b0; lat = 2;
    t_valid = 1'b1; t_we = 1'b1; t_addr = 32'h20; t_wdata = 32'h12345678; t_be = 4'b1111;
    tick();
    t_valid = 1'b0;
    chk(32'(o_rsp_valid), 32'd0, "rwait.in_wait");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(32'(o_req_ready), 32'd1, "rwait.req_ready");
    for (int i = 0; i < 3; i++) begin
      chk(32'(o_rsp_valid), 32'd0, "rwait.no_rsp");
      tick();
    end
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 0, "rwait.ld_prior");

    // Reset while a response is being presented, on both instances.
    for (int s = 0; s < 2; s++) begin
      int n;
      sel = s[0];
      lat = (s == 0) ? 2 : 1;
      t_valid = 1'b1; t_we = 1'b0; t_addr = 32'h10; t_be = 4'b0000;
      tick();
      t_valid = 1'b0;
      n = 1;
      while (!o_rsp_valid && n < 40) begin
        tick();
        n++;
      end
      chk(32'(o_rsp_valid), 32'd1, "rresp.valid_before");
      chk(o_rsp_rdata, 32'hDEADBEAA, "rresp.rdata_before");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(32'(o_rsp_valid), 32'd0, "rresp.valid_after");
      chk(o_rsp_rdata, 32'h0, "rresp.rdata_after");
      chk(32'(o_req_ready), 32'd1, "rresp.req_ready");
      txn(1'b0, 32'h3FC, 32'h0, 4'b0000, 32'hA5A5C3C3, 1'b0, 0, "rresp.ld_kept");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words in the array; address range is 0 .. 4*DEPTH_WORDS-1.
REQ-002 Parameter LATENCY, default 2, legal 1..15, SHALL set the number of cycles from request acceptance to the rsp_valid rising edge.
REQ-003 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i selects byte lane i.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-017 On acceptance the block SHALL capture we/addr/wdata/be, load the counter with LATENCY-1 and enter WAIT; with LATENCY=1 it SHALL go directly to RESP.
REQ-018 WAIT SHALL decrement the counter each cycle and enter RESP when the counter reaches 0 (no wrap).
REQ-019 rsp_valid SHALL be 1 exactly in RESP, i.e. LATENCY cycles after the acceptance edge.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-021 A request with req_valid high while a transaction is outstanding SHALL be held and not accepted.
REQ-022 A new request SHALL NOT be accepted in the same cycle as response completion; the minimum request spacing is LATENCY+1 cycles.
REQ-023 rsp_err SHALL be 1 if addr[1:0] != 0 or addr >= 4*DEPTH_WORDS.
REQ-024 An errored store SHALL leave the array unmodified; an errored load SHALL return rdata 0.
REQ-025 A store SHALL write the enabled byte lanes of word addr[31:2] on the edge entering RESP; be=0000 SHALL write nothing and still respond.
REQ-026 A load SHALL return the word as of the edge entering RESP; a load SHALL observe every store that completed earlier.
REQ-027 Inputs other than req_valid SHALL be ignored outside the acceptance edge.

Reset
REQ-028 On reset the FSM SHALL be in IDLE, the counter 0, and outputs req_ready=1 (first cycle after reset), rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-029 Reset during WAIT SHALL abort the transaction with no array write and no response.
REQ-030 Reset during RESP SHALL drop rsp_valid with no handshake.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 State encodings (IDLE=0, WAIT=1, RESP=2) and default parameter constants SHALL live in shared package dmem_pkg.
REQ-033 Storage SHALL be a sub-module dmem_array: a single-port synchronous array with a 4-bit byte-write mask; the FSM and error logic stay in dmem_responder.

Verification
REQ-034 Store 0xDEADBEEF to addr 0x10 with be=1111, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises exactly 2 cycles after each acceptance.
REQ-035 Store 0x000000AA to addr 0x10 with be=0001 over 0xDEADBEEF, then load 0x10 -> 0xDEADBEAA.
REQ-036 Load addr 0x13, then store to 0x400 with DEPTH_WORDS=256 -> both rsp_err=1, load rsp_rdata=0, array unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stay stable and req_ready=0 throughout; the new request is accepted the cycle after rsp_ready=1.
REQ-038 Pulse reset in WAIT of a store of 0x12345678 to 0x20 -> no response, req_ready=1 next cycle, and a later load of 0x20 returns the prior value.
REQ-039 Repeat the checks with LATENCY=1 -> rsp_valid asserts on the cycle after acceptance.
